w5500_spi_arbiter: RTL

//  Shares the single W5500 SPI transaction engine between NREQ task controllers (init, socket rx, socket tx, irq poll).

---
 rtl/w5500_spi_arbiter_if.sv | 46 ++++
 rtl/w5500_spi_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/w5500_spi_arbiter_if.sv
// Bus bundle between the W5500 SPI arbiter, its NREQ task controllers and the shared SPI engine.
// The slave modport is the arbiter's view; the master modport is the surrounding environment.
interface w5500_spi_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]    req_start;
    logic [NREQ*8-1:0]  req_cmd;
    logic [NREQ*16-1:0] req_addr;
    logic [NREQ*16-1:0] req_length;
    logic [NREQ*8-1:0]  req_dat;
    logic [NREQ-1:0]    req_wrend;
    logic [NREQ-1:0]    req_rdreq;
    logic [NREQ-1:0]    req_den;
    logic [7:0]         req_din;

    logic               m_start;
    logic [7:0]         m_cmd;
    logic [15:0]        m_addr;
    logic [15:0]        m_length;
    logic [7:0]         m_dat;
    logic               m_wrend;
    logic               m_rdreq;
    logic               m_den;
    logic [7:0]         m_din;

    logic               busy;
    logic [2:0]         grant_idx;
    logic               o_drop;
    logic               o_timeout;

    modport slave (
        input  req_start, req_cmd, req_addr, req_length, req_dat,
        output req_wrend, req_rdreq, req_den, req_din,
        output m_start, m_cmd, m_addr, m_length, m_dat,
        input  m_wrend, m_rdreq, m_den, m_din,
        output busy, grant_idx, o_drop, o_timeout
    );

    modport master (
        output req_start, req_cmd, req_addr, req_length, req_dat,
        input  req_wrend, req_rdreq, req_den, req_din,
        input  m_start, m_cmd, m_addr, m_length, m_dat,
        output m_wrend, m_rdreq, m_den, m_din,
        input  busy, grant_idx, o_drop, o_timeout
    );
endinterface

// File: rtl/w5500_spi_arbiter.sv
// Round-robin arbiter sharing one W5500 SPI transaction engine between NREQ requesters,
// with one queued request per requester, strobe routing to the grant and a BUSY watchdog.
module w5500_spi_arbiter #(
    parameter int NREQ    = 4,
    parameter int TMO_W   = 16,
    parameter int TMO_MAX = 50000
) (
    input logic              clk,
    input logic              rst_n,
    w5500_spi_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, GAP} state_t;

    state_t              state_q, state_d;
    logic [NREQ-1:0]     pending_q, pending_d;
    logic [2:0]          lastGrant_q, lastGrant_d;
    logic [2:0]          grantIdx_q, grantIdx_d;
    logic [7:0]          mCmd_q, mCmd_d;
    logic [15:0]         mAddr_q, mAddr_d;
    logic [15:0]         mLen_q, mLen_d;
    logic [TMO_W-1:0]    wdog_q, wdog_d;

    logic [7:0]          cmdSlot_q  [NREQ];
    logic [15:0]         addrSlot_q [NREQ];
    logic [15:0]         lenSlot_q  [NREQ];

    logic                foundHi, foundLo, anyPend, grantNow;
    logic [2:0]          winHi, winLo, winner;
    logic [NREQ-1:0]     capture;
    logic [NREQ-1:0]     wrendVec, rdreqVec, denVec;
    logic                mStart, timeoutPulse;
    logic [7:0]          mDat;

    // Round-robin: prefer the lowest pending index above the last grant, else wrap to the lowest overall.
    always_comb begin
        foundHi = 1'b0;
        foundLo = 1'b0;
        winHi   = '0;
        winLo   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (pending_q[i] && (3'(i) > lastGrant_q)) begin
                foundHi = 1'b1;
                winHi   = 3'(i);
            end
            if (pending_q[i] && (3'(i) <= lastGrant_q)) begin
                foundLo = 1'b1;
                winLo   = 3'(i);
            end
        end
        anyPend  = foundHi | foundLo;
        winner   = foundHi ? winHi : winLo;
        grantNow = (state_q == IDLE) && anyPend;
    end

    // A new pulse on the requester being granted this cycle is captured rather than dropped.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            capture[i] = bus.req_start[i] &&
                         (!pending_q[i] || (grantNow && (winner == 3'(i))));
        end
    end

    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        lastGrant_d  = lastGrant_q;
        grantIdx_d   = grantIdx_q;
        mCmd_d       = mCmd_q;
        mAddr_d      = mAddr_q;
        mLen_d       = mLen_q;
        wdog_d       = wdog_q;
        mStart       = 1'b0;
        timeoutPulse = 1'b0;
        wrendVec     = '0;
        rdreqVec     = '0;
        denVec       = '0;

        case (state_q)
            IDLE: begin
                if (anyPend) begin
                    grantIdx_d = winner;
                    for (int i = 0; i < NREQ; i++) begin
                        if (winner == 3'(i)) begin
                            pending_d[i] = 1'b0;
                            mCmd_d       = cmdSlot_q[i];
                            mAddr_d      = addrSlot_q[i];
                            mLen_d       = lenSlot_q[i];
                        end
                    end
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                mStart  = 1'b1;
                wdog_d  = '0;
                state_d = BUSY;
            end
            BUSY: begin
                wdog_d = wdog_q + 1'b1;
                for (int i = 0; i < NREQ; i++) begin
                    if (grantIdx_q == 3'(i)) begin
                        rdreqVec[i] = bus.m_rdreq;
                        denVec[i]   = bus.m_den;
                    end
                end
                if (bus.m_wrend || (wdog_q == TMO_W'(TMO_MAX - 1))) begin
                    timeoutPulse = !bus.m_wrend;
                    for (int i = 0; i < NREQ; i++) begin
                        if (grantIdx_q == 3'(i)) begin
                            wrendVec[i] = 1'b1;
                        end
                    end
                    lastGrant_d = grantIdx_q;
                    state_d     = GAP;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        pending_d = pending_d | capture;
    end

    always_comb begin
        mDat = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grantIdx_q == 3'(i)) begin
                mDat = bus.req_dat[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            lastGrant_q <= 3'(NREQ - 1);
            grantIdx_q  <= '0;
            mCmd_q      <= '0;
            mAddr_q     <= '0;
            mLen_q      <= '0;
            wdog_q      <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            lastGrant_q <= lastGrant_d;
            grantIdx_q  <= grantIdx_d;
            mCmd_q      <= mCmd_d;
            mAddr_q     <= mAddr_d;
            mLen_q      <= mLen_d;
            wdog_q      <= wdog_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREQ; i++) begin
                cmdSlot_q[i]  <= '0;
                addrSlot_q[i] <= '0;
                lenSlot_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (capture[i]) begin
                    cmdSlot_q[i]  <= bus.req_cmd[8*i +: 8];
                    addrSlot_q[i] <= bus.req_addr[16*i +: 16];
                    lenSlot_q[i]  <= bus.req_length[16*i +: 16];
                end
            end
        end
    end

    assign bus.req_wrend = wrendVec;
    assign bus.req_rdreq = rdreqVec;
    assign bus.req_den   = denVec;
    assign bus.req_din   = bus.m_din;
    assign bus.m_start   = mStart;
    assign bus.m_cmd     = mCmd_q;
    assign bus.m_addr    = mAddr_q;
    assign bus.m_length  = mLen_q;
    assign bus.m_dat     = mDat;
    assign bus.busy      = (state_q != IDLE);
    assign bus.grant_idx = grantIdx_q;
    assign bus.o_drop    = |(bus.req_start & ~capture);
    assign bus.o_timeout = timeoutPulse;

endmodule
